// File: rtl/i2s_pkg.sv
// Shared defaults, receiver state encoding and stereo-pair type for the I2S record path.
package i2s_pkg;

  localparam int unsigned SAMPLE_BITS_DEF       = 16;
  localparam int unsigned MIN_MCLK_PER_BCLK_DEF = 4;

  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    LEFT      = 2'd1,
    RIGHT     = 2'd2
  } rx_state_e;

  typedef struct packed {
    logic signed [SAMPLE_BITS_DEF-1:0] left;
    logic signed [SAMPLE_BITS_DEF-1:0] right;
  } stereo_pair_t;

  function automatic logic [7:0] next_frame_count(input logic [7:0] count);
    return count + 8'd1;
  endfunction

endpackage

// File: rtl/i2s_sync.sv
// Two-flop synchronizer for one asynchronous codec line, with rising-edge detect
// on the synchronized value.
module i2s_sync
  import i2s_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Metastability filter plus one history flop for the edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/i2s_receiver.sv
// I2S record-path receiver: recovers left/right words from an asynchronous codec
// bit clock and presents each complete stereo pair through a valid/ready handshake.
module i2s_receiver
  import i2s_pkg::*;
#(
  parameter int unsigned SAMPLE_BITS       = SAMPLE_BITS_DEF,
  parameter int unsigned MIN_MCLK_PER_BCLK = MIN_MCLK_PER_BCLK_DEF
) (
  input  logic                          mclk,
  input  logic                          rst_n,
  input  logic                          audio_I2S_bclk,
  input  logic                          audio_I2S_reclrc,
  input  logic                          audio_I2S_recdat,
  output logic signed [SAMPLE_BITS-1:0] sample_left,
  output logic signed [SAMPLE_BITS-1:0] sample_right,
  output logic                          sample_valid,
  input  logic                          sample_ready,
  output logic                          overrun,
  input  logic                          overrun_clr,
  output logic                          frame_error,
  output logic [7:0]                    frame_count
);

  localparam int unsigned CNT_W = $clog2(SAMPLE_BITS + 32'd1) + 32'd1;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SAMPLE_BITS - 32'd1);
  // Below the supported MCLK/BCLK ratio the receiver is parked rather than run unreliably.
  localparam logic RATIO_OK = (MIN_MCLK_PER_BCLK >= 32'd4) ? 1'b1 : 1'b0;

  logic                   w_bclk_s_unused;
  logic                   w_bclk_rise_raw;
  logic                   w_bclk_rise;
  logic                   w_lr_s;
  logic                   w_lr_rise_unused;
  logic                   w_dat_s;
  logic                   w_dat_rise_unused;
  logic [SAMPLE_BITS-1:0] w_word;
  logic                   w_len_ok;
  logic                   w_shift_msb_unused;

  rx_state_e              r_state;
  logic [SAMPLE_BITS-1:0] r_shift;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic                   r_lr_prev;
  logic [SAMPLE_BITS-1:0] r_left_hold;
  logic [SAMPLE_BITS-1:0] r_right_hold;
  logic                   r_deliver;
  logic                   r_frame_error;

  logic [SAMPLE_BITS-1:0] r_sample_left;
  logic [SAMPLE_BITS-1:0] r_sample_right;
  logic                   r_sample_valid;
  logic                   r_overrun;
  logic [7:0]             r_frame_count;

  i2s_sync u_sync_bclk (
    .clk     (mclk),
    .rst_n   (rst_n),
    .i_async (audio_I2S_bclk),
    .o_sync  (w_bclk_s_unused),
    .o_rise  (w_bclk_rise_raw)
  );

  i2s_sync u_sync_lr (
    .clk     (mclk),
    .rst_n   (rst_n),
    .i_async (audio_I2S_reclrc),
    .o_sync  (w_lr_s),
    .o_rise  (w_lr_rise_unused)
  );

  i2s_sync u_sync_dat (
    .clk     (mclk),
    .rst_n   (rst_n),
    .i_async (audio_I2S_recdat),
    .o_sync  (w_dat_s),
    .o_rise  (w_dat_rise_unused)
  );

  assign w_bclk_rise        = w_bclk_rise_raw & RATIO_OK;
  assign w_word             = {r_shift[SAMPLE_BITS-2:0], w_dat_s};
  assign w_len_ok           = (r_bit_cnt == LAST_BIT);
  assign w_shift_msb_unused = r_shift[SAMPLE_BITS-1];

  // Word framing state machine; a word-select change marks the LSB of the previous word.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= SYNC_WAIT;
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_lr_prev     <= 1'b0;
      r_left_hold   <= '0;
      r_right_hold  <= '0;
      r_deliver     <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_deliver     <= 1'b0;
      r_frame_error <= 1'b0;
      if (w_bclk_rise) begin
        r_shift   <= w_word;
        r_lr_prev <= w_lr_s;
        if (w_lr_s != r_lr_prev) begin
          r_bit_cnt <= '0;
          case (r_state)
            SYNC_WAIT: begin
              if (r_lr_prev) begin
                r_state <= LEFT;
              end else begin
                r_state <= SYNC_WAIT;
              end
            end
            LEFT: begin
              if (w_len_ok && !r_lr_prev) begin
                r_left_hold <= w_word;
                r_state     <= RIGHT;
              end else begin
                r_frame_error <= 1'b1;
                r_state       <= SYNC_WAIT;
              end
            end
            RIGHT: begin
              if (w_len_ok && r_lr_prev) begin
                r_right_hold <= w_word;
                r_deliver    <= 1'b1;
                r_state      <= LEFT;
              end else begin
                r_frame_error <= 1'b1;
                r_state       <= SYNC_WAIT;
              end
            end
            default: begin
              r_state <= SYNC_WAIT;
            end
          endcase
        end else if (r_bit_cnt != CNT_MAX) begin
          r_bit_cnt <= r_bit_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          r_bit_cnt <= r_bit_cnt;
        end
      end
    end
  end

  // Output holding stage: a new pair overwrites an unaccepted one and flags overrun.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample_left  <= '0;
      r_sample_right <= '0;
      r_sample_valid <= 1'b0;
      r_overrun      <= 1'b0;
      r_frame_count  <= 8'd0;
    end else begin
      if (r_deliver) begin
        r_sample_left  <= r_left_hold;
        r_sample_right <= r_right_hold;
        r_frame_count  <= next_frame_count(r_frame_count);
        r_sample_valid <= 1'b1;
      end else if (r_sample_valid && sample_ready) begin
        r_sample_valid <= 1'b0;
      end else begin
        r_sample_valid <= r_sample_valid;
      end

      if (r_deliver && r_sample_valid && !sample_ready) begin
        r_overrun <= 1'b1;
      end else if (overrun_clr) begin
        r_overrun <= 1'b0;
      end else begin
        r_overrun <= r_overrun;
      end
    end
  end

  assign sample_left  = r_sample_left;
  assign sample_right = r_sample_right;
  assign sample_valid = r_sample_valid;
  assign overrun      = r_overrun;
  assign frame_error  = r_frame_error;
  assign frame_count  = r_frame_count;

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: codec-side I2S frames driven against a free-running
// mclk, with hand-computed expectations checked by immediate assertions.
module tb_i2s_receiver;

  logic               mclk = 1'b0;
  logic               rst_n;
  logic               bclk;
  logic               lrc;
  logic               dat;
  logic               ready;
  logic               clr;
  logic signed [15:0] sl;
  logic signed [15:0] sr;
  logic               sv;
  logic               ovr;
  logic               ferr;
  logic [7:0]         fc;

  int checks   = 0;
  int errors   = 0;
  int ferr_cnt = 0;
  int half     = 4;

  i2s_receiver #(.SAMPLE_BITS(16), .MIN_MCLK_PER_BCLK(4)) dut (
    .mclk             (mclk),
    .rst_n            (rst_n),
    .audio_I2S_bclk   (bclk),
    .audio_I2S_reclrc (lrc),
    .audio_I2S_recdat (dat),
    .sample_left      (sl),
    .sample_right     (sr),
    .sample_valid     (sv),
    .sample_ready     (ready),
    .overrun          (ovr),
    .overrun_clr      (clr),
    .frame_error      (ferr),
    .frame_count      (fc)
  );

  always #5 mclk = ~mclk;

  always @(negedge mclk) begin
    if (ferr === 1'b1) ferr_cnt++;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: plain slot; 1: check delivery latency; 2: raise ready on the delivery edge only
  task automatic slot(input logic lr, input logic d, input int mode);
    @(negedge mclk);
    bclk = 1'b0;
    lrc  = lr;
    dat  = d;
    repeat (half) @(negedge mclk);
    bclk = 1'b1;
    if (mode == 1) begin
      repeat (3) @(posedge mclk);
      #1;
      check("latency_e2", 16'(sv), 16'd0);
      @(posedge mclk);
      #1;
      check("latency_e3", 16'(sv), 16'd1);
    end else if (mode == 2) begin
      repeat (3) @(posedge mclk);
      #1;
      ready = 1'b1;
      @(posedge mclk);
      #1;
      ready = 1'b0;
    end else begin
      repeat (half - 1) @(negedge mclk);
    end
  endtask

  // nl = left bits sent while word select is low (15 for a well-formed word)
  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int nl, input int mode);
    for (int i = 15; i > 15 - nl; i--) slot(1'b0, l[i], 0);
    slot(1'b1, l[0], 0);
    for (int i = 15; i >= 1; i--) slot(1'b1, r[i], 0);
    slot(1'b0, r[0], mode);
    repeat (4) @(negedge mclk);
  endtask

  initial begin
    rst_n = 1'b0;
    bclk  = 1'b0;
    lrc   = 1'b1;
    dat   = 1'b0;
    ready = 1'b0;
    clr   = 1'b0;
    repeat (4) @(negedge mclk);
    check("rst_valid", 16'(sv), 16'd0);
    check("rst_left", sl, 16'h0000);
    check("rst_right", sr, 16'h0000);
    check("rst_overrun", 16'(ovr), 16'd0);
    check("rst_ferr", 16'(ferr), 16'd0);
    check("rst_count", 16'(fc), 16'd0);

    // Startup: reset released in the middle of a right word
    for (int i = 0; i < 5; i++) slot(1'b1, 1'b1, 0);
    @(negedge mclk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) slot(1'b1, 1'b0, 0);
    slot(1'b0, 1'b1, 0);
    repeat (4) @(negedge mclk);
    check("startup_no_valid", 16'(sv), 16'd0);
    check("startup_count", 16'(fc), 16'd0);

    // Basic pair with latency measurement, ready held low
    send_frame(16'h8001, 16'h7FFE, 15, 1);
    check("basic_valid", 16'(sv), 16'd1);
    check("basic_left", sl, 16'h8001);
    check("basic_right", sr, 16'h7FFE);
    check("basic_count", 16'(fc), 16'd1);
    check("basic_overrun", 16'(ovr), 16'd0);

    // Overrun: second frame lands on an unaccepted pair
    send_frame(16'h1234, 16'hABCD, 15, 0);
    check("ovr_left", sl, 16'h1234);
    check("ovr_right", sr, 16'hABCD);
    check("ovr_count", 16'(fc), 16'd2);
    check("ovr_flag", 16'(ovr), 16'd1);
    @(negedge mclk);
    clr = 1'b1;
    @(negedge mclk);
    clr = 1'b0;
    check("ovr_cleared", 16'(ovr), 16'd0);
    check("ovr_valid_held", 16'(sv), 16'd1);

    // Accept, then ready while idle must change nothing
    ready = 1'b1;
    @(negedge mclk);
    ready = 1'b0;
    check("accept_valid", 16'(sv), 16'd0);
    ready = 1'b1;
    repeat (3) @(negedge mclk);
    ready = 1'b0;
    check("idle_ready_valid", 16'(sv), 16'd0);
    check("idle_ready_count", 16'(fc), 16'd2);
    check("idle_ready_left", sl, 16'h1234);

    // Coincident delivery and acceptance
    send_frame(16'h0F0F, 16'hF0F0, 15, 0);
    check("pre_coin_valid", 16'(sv), 16'd1);
    send_frame(16'h5A5A, 16'hA5A5, 15, 2);
    check("coin_valid", 16'(sv), 16'd1);
    check("coin_left", sl, 16'h5A5A);
    check("coin_right", sr, 16'hA5A5);
    check("coin_overrun", 16'(ovr), 16'd0);
    check("coin_count", 16'(fc), 16'd4);
    ready = 1'b1;
    @(negedge mclk);
    ready = 1'b0;

    // Short left word: error pulse, pair dropped, recovery on next frame
    send_frame(16'hDEAD, 16'hBEEF, 14, 0);
    check("short_ferr_pulses", 16'(ferr_cnt), 16'd1);
    check("short_count", 16'(fc), 16'd4);
    check("short_valid", 16'(sv), 16'd0);
    send_frame(16'h1357, 16'h2468, 15, 0);
    check("resume_valid", 16'(sv), 16'd1);
    check("resume_left", sl, 16'h1357);
    check("resume_right", sr, 16'h2468);
    check("resume_count", 16'(fc), 16'd5);
    check("resume_ferr_pulses", 16'(ferr_cnt), 16'd1);

    // Reset mid-word with a pair pending
    for (int i = 15; i >= 8; i--) slot(1'b0, 1'b1, 0);
    @(negedge mclk);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 16'(sv), 16'd0);
    check("midrst_left", sl, 16'h0000);
    check("midrst_count", 16'(fc), 16'd0);
    repeat (2) @(negedge mclk);
    rst_n = 1'b1;
    for (int i = 7; i >= 1; i--) slot(1'b0, 1'b1, 0);
    slot(1'b1, 1'b1, 0);
    for (int i = 0; i < 15; i++) slot(1'b1, 1'b0, 0);
    slot(1'b0, 1'b1, 0);
    repeat (4) @(negedge mclk);
    check("postrst_valid", 16'(sv), 16'd0);
    check("postrst_count", 16'(fc), 16'd0);

    // Wrap: 256 pairs at the minimum supported ratio with ready held high
    ready = 1'b1;
    half  = 2;
    for (int k = 0; k < 255; k++) send_frame(16'(k * 3), ~16'(k), 15, 0);
    check("wrap_255", 16'(fc), 16'd255);
    check("wrap_255_overrun", 16'(ovr), 16'd0);
    send_frame(16'hC3C3, 16'h3C3C, 15, 0);
    check("wrap_0", 16'(fc), 16'd0);
    check("wrap_left", sl, 16'hC3C3);
    check("wrap_right", sr, 16'h3C3C);
    check("wrap_accepted", 16'(sv), 16'd0);
    check("wrap_overrun", 16'(ovr), 16'd0);
    check("wrap_no_ferr", 16'(ferr_cnt), 16'd1);
    ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_receiver.md
I2S_RECEIVER -- requirements
Module: i2s_receiver

Interface
REQ-001 The module SHALL have parameter SAMPLE_BITS, default 16, meaning bits per channel word and BCLK periods per LRCLK half-period.
REQ-002 The module SHALL have parameter MIN_MCLK_PER_BCLK, default 4, meaning the minimum MCLK periods per BCLK period supported; any smaller ratio is out of scope.
REQ-003 The module SHALL have port mclk, input, 1 bit: the single clock; all logic uses its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 The module SHALL have port audio_I2S_bclk, input, 1 bit: the codec bit clock, asynchronous to mclk.
REQ-006 The module SHALL have port audio_I2S_reclrc, input, 1 bit: record word select; 0 means left, 1 means right.
REQ-007 The module SHALL have port audio_I2S_recdat, input, 1 bit: record data, MSB first, I2S one-bit delay.
REQ-008 The module SHALL have port sample_left, output, SAMPLE_BITS bits, signed: the captured left word.
REQ-009 The module SHALL have port sample_right, output, SAMPLE_BITS bits, signed: the captured right word.
REQ-010 The module SHALL have port sample_valid, output, 1 bit: a stereo pair is held on the outputs.
REQ-011 The module SHALL have port sample_ready, input, 1 bit: the consumer accepts the pair.
REQ-012 The module SHALL have port overrun, output, 1 bit: sticky flag, set when an unconsumed pair is overwritten.
REQ-013 The module SHALL have port overrun_clr, input, 1 bit: synchronous clear of overrun.
REQ-014 The module SHALL have port frame_error, output, 1 bit: one-cycle pulse on word-length mismatch.
REQ-015 The module SHALL have port frame_count, output, 8 bits: count of delivered pairs, wrapping 255 to 0.

Function
REQ-016 The block SHALL pass bclk, reclrc and recdat each through a 2-flop synchronizer; a BCLK rise is synced bclk being 1 now and 0 on the previous cycle.
REQ-017 On each BCLK rise, the block SHALL shift synced recdat into a SAMPLE_BITS shift register and increment a bit counter.
REQ-018 On each BCLK rise, the block SHALL compare synced reclrc with the value lr_prev stored at the previous BCLK rise; on a mismatch, the current bit is the LSB of the word belonging to lr_prev.
REQ-019 At a word end, the bit counter including the LSB SHALL equal SAMPLE_BITS; the word is stored to the left or right holding register according to lr_prev, and the counter then resets to 0.
REQ-020 On a count mismatch at word end, the block SHALL discard the word, pulse frame_error for 1 cycle, and enter SYNC_WAIT.
REQ-021 The state machine SHALL have states SYNC_WAIT, LEFT and RIGHT.
REQ-022 SYNC_WAIT SHALL go to LEFT on a reclrc 1→0 change, without storing a word.
REQ-023 LEFT SHALL go to RIGHT on a valid left word end.
REQ-024 RIGHT SHALL go to LEFT on a valid right word end and SHALL deliver the pair.
REQ-025 Bits captured in SYNC_WAIT SHALL never reach the outputs.
REQ-026 Delivery SHALL load sample_left, sample_right and frame_count+1, and SHALL assert sample_valid on the next mclk edge.
REQ-027 sample_valid SHALL rise exactly 3 mclk edges after the edge at which sync stage 1 first captures BCLK high for the right LSB.
REQ-028 Handshake: sample_valid SHALL stay high and the outputs SHALL stay stable until a cycle in which sample_valid and sample_ready are both 1, after which sample_valid falls.
REQ-029 When delivery coincides with acceptance, the block SHALL load the new pair, keep sample_valid at 1, and leave overrun unchanged.
REQ-030 When delivery occurs while sample_valid is 1 and sample_ready is 0, the block SHALL overwrite the pair and set overrun.
REQ-031 overrun_clr SHALL clear overrun; a set in the same cycle SHALL win over the clear.
REQ-032 When sample_ready is 1 while sample_valid is 0, the block SHALL take no action.

Reset
REQ-033 While rst_n is 0, sample_left, sample_right, sample_valid, overrun, frame_error and frame_count SHALL be 0, the state SHALL be SYNC_WAIT, and the synchronizers, shift register, bit counter and lr_prev SHALL be 0.
REQ-034 When reset asserts mid-word or mid-handshake, the block SHALL drop the pending pair immediately; after release it SHALL resynchronize only on the next reclrc 1→0.

Structure
REQ-035 Package i2s_pkg SHALL hold the SAMPLE_BITS default, the rx state enum (SYNC_WAIT, LEFT, RIGHT), and the stereo-pair struct type.
REQ-036 Sub-module i2s_sync SHALL implement the 2-flop synchronizer plus rise detect, with 3 instances.

Verification
REQ-037 Scenario, basic pair: MCLK/BCLK ratio 8, send left 16'h8001 and right 16'h7FFE, hold ready=0 → sample_valid=1, sample_left=16'h8001, sample_right=16'h7FFE, frame_count=1, and the latency of REQ-027 is met.
REQ-038 Scenario, startup: release reset mid-right-word → the first pair delivered is the first complete left/right after reclrc 1→0, and no partial pair is delivered.
REQ-039 Scenario, overrun: keep ready=0 for 2 frames → outputs show the second pair and overrun=1; pulse overrun_clr → overrun=0.
REQ-040 Scenario, coincident accept: assert ready exactly on the delivery cycle → sample_valid stays 1 with the new pair and overrun=0.
REQ-041 Scenario, short word: send a 15-bit left half-frame → frame_error pulses once, the next pair is dropped, and after the next reclrc 1→0 pairs resume correctly.
REQ-042 Scenario, wrap: deliver 256 pairs with ready=1 → frame_count returns to 0 and no overrun occurs.
